instr_fetch: RTL and testbench

//   Instruction fetch front end: owns the PC, drives the word-addressed instruction ROM
//   (combinational read, data valid the same cycle), and buffers fetched words in a 2-entry

---
 rtl/instr_fetch.sv | 165 ++++++++++++++++
 tb/tb_instr_fetch.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch front end. Owns the PC and drives a word-addressed
//   instruction ROM that returns data combinationally in the same cycle.
//   Fetched words go into a 2-entry registered queue. The queue is presented
//   to decode over a valid/ready handshake.
//   A redirect from execute flushes the wrong-path words and reloads the PC.
//   If the fetcher pushes a jump to its own address (the idle loop), it parks
//   in HALTED until the next redirect.
//
// Ports
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   fetch_en        level; fetching is allowed while high
//   imem_addr       ROM word address; always equals the PC
//   imem_data       ROM read data, combinational from imem_addr
//   instr_valid     queue head valid
//   instr_ready     decode accepts the head this cycle
//   instr           head instruction word; holds its last value when empty
//   instr_pc        head instruction address; holds its last value when empty
//   redirect_valid  one-cycle pulse: flush the queue and load redirect_pc
//   redirect_pc     new fetch address
//   halted          a self-jump was fetched and fetching has stopped
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int                ADDR_W   = 5,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED
  } state_e;

  state_e            state_q;
  logic              halted_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        count_q, count_d;

  // The queue is a two-slot shift register. The head slot drives the outputs
  // directly, so instr/instr_pc keep their last values when the queue empties.
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [ADDR_W-1:0] head_pc_q, head_pc_d;
  logic [DATA_W-1:0] tail_data_q, tail_data_d;
  logic [ADDR_W-1:0] tail_pc_q, tail_pc_d;

  logic       pop;
  logic       push;
  logic       self_jump;
  logic [1:0] fill_slot;

  assign imem_addr   = pc_q;
  assign instr_valid = (count_q != 2'd0);
  assign instr       = head_data_q;
  assign instr_pc    = head_pc_q;
  assign halted      = halted_q;

  // A redirect overrides the handshake. A word offered in the same cycle is
  // not consumed because it is flushed anyway.
  assign pop  = instr_valid & instr_ready & ~redirect_valid;
  assign push = (state_q == S_RUN) & ~redirect_valid &
                ((count_q < 2'd2) | (instr_valid & instr_ready));

  // Self-jump: an unconditional J opcode whose target is its own address.
  assign self_jump = (imem_data[DATA_W-1 -: 6] == 6'b000010) &&
                     (imem_data[ADDR_W-1:0] == pc_q);

  // Slot that receives a new word once this cycle's pop has been applied.
  assign fill_slot = count_q - 2'(pop);

  // NOTE: every signal assigned in this block gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    pc_d        = pc_q;
    count_d     = count_q;
    head_data_d = head_data_q;
    head_pc_d   = head_pc_q;
    tail_data_d = tail_data_q;
    tail_pc_d   = tail_pc_q;

    if (redirect_valid) begin
      pc_d    = redirect_pc;
      count_d = 2'd0;
    end else begin
      if (pop && count_q == 2'd2) begin
        head_data_d = tail_data_q;
        head_pc_d   = tail_pc_q;
      end
      if (push) begin
        if (fill_slot == 2'd0) begin
          head_data_d = imem_data;
          head_pc_d   = pc_q;
        end else begin
          tail_data_d = imem_data;
          tail_pc_d   = pc_q;
        end
        // The PC stays on the self-jump so the parked address is visible.
        if (!self_jump) pc_d = pc_q + 1'b1;
      end
      count_d = count_q - 2'(pop) + 2'(push);
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      count_q     <= 2'd0;
      head_data_q <= '0;
      head_pc_q   <= '0;
      tail_data_q <= '0;
      tail_pc_q   <= '0;
    end else begin
      pc_q        <= pc_d;
      count_q     <= count_d;
      head_data_q <= head_data_d;
      head_pc_q   <= head_pc_d;
      tail_data_q <= tail_data_d;
      tail_pc_q   <= tail_pc_d;
    end
  end

  // Control FSM with a registered halted flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      halted_q <= 1'b0;
    end else if (redirect_valid) begin
      state_q  <= fetch_en ? S_RUN : S_IDLE;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fetch_en) state_q <= S_RUN;
        end
        S_RUN: begin
          if (push && self_jump) begin
            state_q  <= S_HALTED;
            halted_q <= 1'b1;
          end else if (!fetch_en) begin
            state_q <= S_IDLE;
          end
        end
        S_HALTED: ;  // only a redirect leaves HALTED
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [31:0] BASE = 32'hC0DE_0000;  // ROM[i] = BASE + i

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fetch_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halted;

  logic [DATA_W-1:0] rom [32];

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  assign imem_data = rom[imem_addr];

  instr_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(5'd0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Assert reset for two edges, then release it just after an edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_en = 1'b1; instr_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    step(); step();
    if (imem_addr !== 5'd0) begin $display("FAIL reset_addr: got %0d want 0", imem_addr); n_mismatched++; end
    n_compared++;
    if (instr_valid !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", instr_valid); n_mismatched++; end
    n_compared++;
    if (instr !== 32'd0) begin $display("FAIL reset_instr: got %h want 0", instr); n_mismatched++; end
    n_compared++;
    if (instr_pc !== 5'd0) begin $display("FAIL reset_instr_pc: got %0d want 0", instr_pc); n_mismatched++; end
    n_compared++;
    if (halted !== 1'b0) begin $display("FAIL reset_halted: got %b want 0", halted); n_mismatched++; end
    n_compared++;
  endtask

  task automatic test_stream();
    rst_n = 1'b1;
    step();  // IDLE -> RUN, nothing fetched yet
    if (instr_valid !== 1'b0) begin $display("FAIL stream_first_edge_valid: got %b want 0", instr_valid); n_mismatched++; end
    n_compared++;
    for (int k = 0; k < 6; k++) begin
      step();
      if (instr_valid !== 1'b1) begin $display("FAIL stream_valid[%0d]: got %b want 1", k, instr_valid); n_mismatched++; end
      n_compared++;
      if (instr_pc !== 5'(k)) begin $display("FAIL stream_pc[%0d]: got %0d want %0d", k, instr_pc, k); n_mismatched++; end
      n_compared++;
      if (instr !== BASE + 32'(k)) begin $display("FAIL stream_instr[%0d]: got %h want %h", k, instr, BASE + 32'(k)); n_mismatched++; end
      n_compared++;
    end
  endtask

  task automatic test_backpressure();
    fetch_en = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0;
    apply_reset();
    step();                              // RUN
    for (int k = 0; k < 4; k++) step();  // ready low for 4 cycles
    if (imem_addr !== 5'd2) begin $display("FAIL bp_addr_stall: got %0d want 2", imem_addr); n_mismatched++; end
    n_compared++;
    if (instr_valid !== 1'b1 || instr_pc !== 5'd0) begin
      $display("FAIL bp_head: got valid=%b pc=%0d want valid=1 pc=0", instr_valid, instr_pc); n_mismatched++;
    end
    n_compared++;
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (instr_valid !== 1'b1 || instr_pc !== 5'(k)) begin
        $display("FAIL bp_drain[%0d]: got valid=%b pc=%0d want valid=1 pc=%0d", k, instr_valid, instr_pc, k); n_mismatched++;
      end
      n_compared++;
      if (instr !== BASE + 32'(k)) begin $display("FAIL bp_drain_instr[%0d]: got %h want %h", k, instr, BASE + 32'(k)); n_mismatched++; end
      n_compared++;
      step();
    end
  endtask

  task automatic test_redirect();
    fetch_en = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0;
    apply_reset();
    for (int k = 0; k < 4; k++) step();  // queue now holds pcs 0 and 1
    redirect_valid = 1'b1; redirect_pc = 5'd3; instr_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    if (instr_valid !== 1'b0) begin $display("FAIL redir_flush_valid: got %b want 0", instr_valid); n_mismatched++; end
    n_compared++;
    if (imem_addr !== 5'd3) begin $display("FAIL redir_addr: got %0d want 3", imem_addr); n_mismatched++; end
    n_compared++;
    if (instr_pc !== 5'd0) begin $display("FAIL redir_hold_pc: got %0d want 0", instr_pc); n_mismatched++; end
    n_compared++;
    step();
    if (instr_valid !== 1'b1 || instr_pc !== 5'd3) begin
      $display("FAIL redir_first: got valid=%b pc=%0d want valid=1 pc=3", instr_valid, instr_pc); n_mismatched++;
    end
    n_compared++;
    step();
    if (instr_valid !== 1'b1 || instr_pc !== 5'd4) begin
      $display("FAIL redir_second: got valid=%b pc=%0d want valid=1 pc=4", instr_valid, instr_pc); n_mismatched++;
    end
    n_compared++;
  endtask

  task automatic test_self_jump();
    int  expected_pc = 0;
    bit  saw_halt    = 1'b0;
    rom[12] = 32'h0800_000C;
    fetch_en = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0;
    apply_reset();
    for (int cyc = 0; cyc < 40 && !saw_halt; cyc++) begin
      step();
      if (instr_valid) begin
        if (instr_pc !== 5'(expected_pc)) begin
          $display("FAIL sj_seq: got pc=%0d want %0d", instr_pc, expected_pc); n_mismatched++;
        end
        n_compared++;
        expected_pc++;
      end
      saw_halt = halted;
    end
    if (!saw_halt || expected_pc != 13) begin
      $display("FAIL sj_halt: got halted=%b delivered=%0d want halted=1 delivered=13", saw_halt, expected_pc); n_mismatched++;
    end
    n_compared++;
    if (instr !== 32'h0800_000C) begin $display("FAIL sj_word: got %h want 0800000c", instr); n_mismatched++; end
    n_compared++;
    for (int k = 0; k < 3; k++) begin
      step();
      if (instr_valid !== 1'b0 || imem_addr !== 5'd12 || halted !== 1'b1) begin
        $display("FAIL sj_parked[%0d]: got valid=%b addr=%0d halted=%b want 0/12/1", k, instr_valid, imem_addr, halted); n_mismatched++;
      end
      n_compared++;
    end
    redirect_valid = 1'b1; redirect_pc = 5'd0;
    step();
    redirect_valid = 1'b0;
    if (halted !== 1'b0 || imem_addr !== 5'd0) begin
      $display("FAIL sj_unpark: got halted=%b addr=%0d want 0/0", halted, imem_addr); n_mismatched++;
    end
    n_compared++;
    step();
    if (instr_valid !== 1'b1 || instr_pc !== 5'd0 || instr !== BASE) begin
      $display("FAIL sj_refetch: got valid=%b pc=%0d instr=%h want 1/0/%h", instr_valid, instr_pc, instr, BASE); n_mismatched++;
    end
    n_compared++;
    rom[12] = BASE + 32'd12;
  endtask

  task automatic test_wrap();
    fetch_en = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0;
    apply_reset();
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 5'd31;
    step();
    redirect_valid = 1'b0;
    if (instr_valid !== 1'b0 || imem_addr !== 5'd31) begin
      $display("FAIL wrap_redirect: got valid=%b addr=%0d want 0/31", instr_valid, imem_addr); n_mismatched++;
    end
    n_compared++;
    for (int k = 0; k < 3; k++) begin
      logic [ADDR_W-1:0] exp_pc;
      exp_pc = 5'd31 + 5'(k);
      step();
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== BASE + 32'(exp_pc)) begin
        $display("FAIL wrap_seq[%0d]: got valid=%b pc=%0d instr=%h want 1/%0d/%h",
                 k, instr_valid, instr_pc, instr, exp_pc, BASE + 32'(exp_pc)); n_mismatched++;
      end
      n_compared++;
    end
  endtask

  task automatic test_async_reset();
    fetch_en = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0;
    apply_reset();
    for (int k = 0; k < 4; k++) step();  // queue full
    #2;
    rst_n = 1'b0;
    #1;  // still well before the next rising edge
    if (instr_valid !== 1'b0 || imem_addr !== 5'd0 || instr !== 32'd0 || instr_pc !== 5'd0 || halted !== 1'b0) begin
      $display("FAIL async_clear: got valid=%b addr=%0d instr=%h pc=%0d halted=%b want all 0",
               instr_valid, imem_addr, instr, instr_pc, halted); n_mismatched++;
    end
    n_compared++;
    step();
    rst_n = 1'b1; instr_ready = 1'b1;
    step();
    if (instr_valid !== 1'b0) begin $display("FAIL async_restart_idle: got %b want 0", instr_valid); n_mismatched++; end
    n_compared++;
    step();
    if (instr_valid !== 1'b1 || instr_pc !== 5'd0) begin
      $display("FAIL async_restart: got valid=%b pc=%0d want 1/0", instr_valid, instr_pc); n_mismatched++;
    end
    n_compared++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = BASE + 32'(i);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_self_jump();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
